// File: rtl/apb_regfile_completer.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_completer
// Brief    : APB4 completer with a bank of 32-bit byte-strobed registers,
//            programmable wait states, address-error response and debug taps.
// Revision : 1.0 - initial release
// ============================================================================
module apb_regfile_completer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0010,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR,
    input  logic [3:0]  dbg_idx,
    output logic [31:0] dbg_data,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
);

    localparam int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] SPAN      = 32'(4 * NUM_REGS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_wait;
    logic [3:0]         w_wait_next;
    logic               r_pready;
    logic               w_pready_next;
    logic               w_latch;
    logic               w_setup;
    logic               w_addr_ok;
    logic [31:0]        w_offset;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_regs [NUM_REGS];
    logic [15:0]        r_wr_count;
    logic [15:0]        r_err_count;

    assign w_setup   = PSEL && !PENABLE;
    assign w_offset  = PADDR - BASE_ADDR;
    assign w_addr_ok = (PADDR[1:0] == 2'b00) && (PADDR >= BASE_ADDR) && (w_offset < SPAN);

    // The wait counter holds the number of access cycles still to spend in
    // ACCESS; with no wait states the first access cycle is already DONE.
    always_comb begin
        w_state_next  = r_state;
        w_wait_next   = r_wait;
        w_pready_next = 1'b0;
        w_latch       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) w_latch = 1'b1;
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    w_state_next = ST_IDLE;
                end else if (PENABLE) begin
                    if (r_wait > 4'd1) begin
                        w_wait_next = r_wait - 4'd1;
                    end else begin
                        w_state_next  = ST_DONE;
                        w_pready_next = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                if (w_setup) w_latch = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_latch) begin
            w_wait_next = WAIT_INIT;
            if (NO_WAIT) begin
                w_state_next  = ST_DONE;
                w_pready_next = 1'b1;
            end else begin
                w_state_next = ST_ACCESS;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_wait      <= 4'd0;
            r_pready    <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= 32'd0;
            r_strb      <= 4'd0;
            r_valid     <= 1'b0;
            r_idx       <= '0;
            r_wr_count  <= 16'd0;
            r_err_count <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_wait   <= w_wait_next;
            r_pready <= w_pready_next;
            if (w_latch) begin
                r_write <= PWRITE;
                r_wdata <= PWDATA;
                r_strb  <= PSTRB;
                r_valid <= w_addr_ok;
                r_idx   <= w_offset[IDX_W+1:2];
            end
            if (r_state == ST_DONE) begin
                if (!r_valid) begin
                    if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                end else if (r_write) begin
                    if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
                    for (int b = 0; b < 4; b++) begin
                        if (r_strb[b]) r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Registers only change on the DONE edge, so reading them during the
    // PREADY cycle always returns the pre-commit contents.
    assign PREADY    = r_pready;
    assign PSLVERR   = r_pready && !r_valid;
    assign PRDATA    = (r_pready && r_valid && !r_write) ? r_regs[r_idx] : 32'd0;
    assign dbg_data  = ({28'd0, dbg_idx} < 32'(NUM_REGS)) ? r_regs[dbg_idx[IDX_W-1:0]] : 32'd0;
    assign wr_count  = r_wr_count;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_completer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regfile_completer
// Brief    : Scoreboard bench; two completers (0 and 3 wait states) share
//            one APB bus with separate selects.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_regfile_completer;

    localparam logic [31:0] BASE = 32'h0000_0010;
    localparam int          NREG = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [3:0]  dbg_idx;
    logic [1:0]  pready;
    logic [1:0]  pslverr;
    logic [31:0] prdata0, prdata1, dbg0, dbg1;
    logic [15:0] wrc0, wrc1, errc0, errc1;

    always #5 aclk = ~aclk;

    apb_regfile_completer #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_CYCLES(0)) u_dut0 (
        .aclk(aclk), .areset(areset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready[0]), .PRDATA(prdata0),
        .PSLVERR(pslverr[0]), .dbg_idx(dbg_idx), .dbg_data(dbg0), .wr_count(wrc0), .err_count(errc0)
    );

    apb_regfile_completer #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_CYCLES(3)) u_dut1 (
        .aclk(aclk), .areset(areset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready[1]), .PRDATA(prdata1),
        .PSLVERR(pslverr[1]), .dbg_idx(dbg_idx), .dbg_data(dbg1), .wr_count(wrc1), .err_count(errc1)
    );

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          start;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mregs [2][NREG];
    int          mwr [2];
    int          merr [2];
    int          waits [2] = '{0, 3};
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mwr[d]  = 0;
            merr[d] = 0;
            for (int i = 0; i < NREG; i++) mregs[d][i] = 32'd0;
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        exp_t        e;
        bit          ok;
        bit          done;
        int          idx;
        logic [31:0] cur;
        ok  = (addr % 4 == 0) && (addr >= BASE) && (addr < BASE + 4 * NREG);
        idx = ok ? int'((addr - BASE) / 4) : 0;
        @(posedge aclk); #1;
        e.d = d; e.err = !ok; e.rdata = 32'd0; e.start = cyc; e.lat = waits[d] + 2;
        if (!ok) begin
            merr[d]++;
        end else if (wr) begin
            mwr[d]++;
            cur = mregs[d][idx];
            for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
            mregs[d][idx] = cur;
        end else begin
            e.rdata = mregs[d][idx];
        end
        sb.push_back(e);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge aclk); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge aclk);
            done = pready[d];
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL pready_timeout: dut%0d got no PREADY, required within 40 cycles", d);
            void'(sb.pop_back());
        end
        @(posedge aclk); #1;
        psel = 2'b00; penable = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check($sformatf("%s wr_count0", tag), {16'd0, wrc0}, 32'(mwr[0]));
        check($sformatf("%s err_count0", tag), {16'd0, errc0}, 32'(merr[0]));
        check($sformatf("%s wr_count1", tag), {16'd0, wrc1}, 32'(mwr[1]));
        check($sformatf("%s err_count1", tag), {16'd0, errc1}, 32'(merr[1]));
    endtask

    // Response monitor: pops one expectation per PREADY, otherwise checks idle outputs.
    always @(negedge aclk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (pready[d]) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_pready: dut%0d got PREADY=1, required 0", d);
                    end else begin
                        mon_e = sb.pop_front();
                        check("resp_dut", 32'(d), 32'(mon_e.d));
                        check("prdata", d == 0 ? prdata0 : prdata1, mon_e.rdata);
                        check("pslverr", {31'd0, pslverr[d]}, {31'd0, mon_e.err});
                        check("latency", 32'(cyc - mon_e.start + 1), 32'(mon_e.lat));
                    end
                end else begin
                    check("idle_prdata", d == 0 ? prdata0 : prdata1, 32'd0);
                    check("idle_pslverr", {31'd0, pslverr[d]}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        int          d;
        areset = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0; dbg_idx = 4'd0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        mon_en = 1'b1;
        check("reset pready", {30'd0, pready}, 32'd0);
        check("reset dbg0", dbg0, 32'd0);
        check_counts("reset");

        // Basic write, byte strobes, read-back
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("tp1 dbg reg0", dbg0, 32'hDEADBEEF);
        check("tp1 wr_count", {16'd0, wrc0}, 32'd1);
        xfer(0, 1'b1, 32'h14, 32'hDEADAAAA, 4'hF);
        xfer(0, 1'b1, 32'h18, 32'hDEADBBBB, 4'hF);
        xfer(0, 1'b1, 32'h1C, 32'hDEADCCCC, 4'hF);
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 4'hF);
        xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
        check("tp3 dbg reg0", dbg0, 32'hDE22BE44);

        // Address errors: below base, past end, misaligned
        xfer(0, 1'b1, 32'h0C, 32'h12345678, 4'hF);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h30, 32'h12345678, 4'hF);
        xfer(0, 1'b0, 32'h30, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h12, 32'h12345678, 4'hF);
        xfer(0, 1'b0, 32'h12, 32'h0, 4'h0);
        check("tp4 err_count", {16'd0, errc0}, 32'd6);
        check("tp4 dbg reg0", dbg0, 32'hDE22BE44);
        check_counts("tp4");

        // Wait-state completer, then an aborted write
        xfer(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
        xfer(1, 1'b0, 32'h14, 32'h0, 4'hF);
        xfer(1, 1'b1, 32'h18, 32'h0, 4'h0);
        @(posedge aclk); #1;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1C; pwdata = 32'hBAADBAAD; pstrb = 4'hF;
        @(posedge aclk); #1 penable = 1'b1;
        @(posedge aclk); #1 psel = 2'b00; penable = 1'b0;
        repeat (6) @(posedge aclk);
        #1 dbg_idx = 4'd3;
        #1 check("abort dbg reg3", dbg1, 32'd0);
        check_counts("abort");

        // Reset in the middle of a waited write
        @(posedge aclk); #1;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h28; pwdata = 32'h55AA55AA; pstrb = 4'hF;
        @(posedge aclk); #1 penable = 1'b1;
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0; psel = 2'b00; penable = 1'b0;
        model_reset();
        dbg_idx = 4'd6;
        #1 check("rst dbg reg6", dbg1, 32'd0);
        check("rst pready", {30'd0, pready}, 32'd0);
        check("rst prdata", prdata1, 32'd0);
        check_counts("rst");
        xfer(1, 1'b1, 32'h28, 32'h0BADF00D, 4'hF);
        check("post-rst dbg reg6", dbg1, 32'h0BADF00D);

        // Randomised traffic on both completers
        for (int n = 0; n < 120; n++) begin
            d = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1: a = BASE + 32'(4 * $urandom_range(0, NREG - 1));
                2:    a = BASE + 32'($urandom_range(0, 4 * NREG + 3)) - 32'd4;
                default: a = $urandom();
            endcase
            w = $urandom();
            xfer(d, 1'($urandom_range(0, 1)), a, w, 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 16; i++) begin
            dbg_idx = 4'(i);
            #1;
            check($sformatf("final dbg0[%0d]", i), dbg0, (i < NREG) ? mregs[0][i % NREG] : 32'd0);
            check($sformatf("final dbg1[%0d]", i), dbg1, (i < NREG) ? mregs[1][i % NREG] : 32'd0);
        end
        check_counts("final");
        repeat (4) @(posedge aclk);
        #1 check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
